// File: rtl/fpu_cmd_queue.sv
// fpu_cmd_queue
// Memory-mapped front end for the pipelined FPU execution unit. Software
// loads operands A/B and writes a command. The command is queued, issued to
// the execution unit over valid/ready, and the result is buffered until
// software reads and pops it. Issue uses credits, so the result queue always
// has room for every operation in flight.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cs, we, addr, wdata     bus window select, write strobe, byte offset, data
//   rdata                   combinational read data
//   exu_valid/ready         issue handshake to the execution unit
//   exu_op, exu_a, exu_b    head command payload
//   res_valid, res_data,    result strobe, value and {NV,OF,UF,NX} flags
//   res_flags
//   busy                    commands queued or operations in flight
module fpu_cmd_queue #(
  parameter int CQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        exu_valid,
  input  logic        exu_ready,
  output logic [1:0]  exu_op,
  output logic [31:0] exu_a,
  output logic [31:0] exu_b,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic [3:0]  res_flags,
  output logic        busy
);

  localparam int CQ_AW = $clog2(CQ_DEPTH);
  localparam int RQ_AW = $clog2(RQ_DEPTH);

  // Word offsets within the window
  localparam logic [5:0] OFF_OPA    = 6'h00;
  localparam logic [5:0] OFF_OPB    = 6'h01;
  localparam logic [5:0] OFF_CMD    = 6'h02;
  localparam logic [5:0] OFF_RESULT = 6'h03;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_POP    = 6'h05;
  localparam logic [5:0] OFF_CLEAR  = 6'h06;

  // Storage: command entry {op, A, B}, result entry {flags, data}
  logic [65:0] cq_mem [CQ_DEPTH];
  logic [35:0] rq_mem [RQ_DEPTH];

  logic [CQ_AW-1:0] cq_rd_ptr_reg, cq_wr_ptr_reg;
  logic [RQ_AW-1:0] rq_rd_ptr_reg, rq_wr_ptr_reg;
  logic [3:0]       cq_count_reg, rq_count_reg;
  logic [3:0]       in_flight_reg, drain_reg;
  logic [3:0]       in_flight_next;
  logic [31:0]      opa_reg, opb_reg;
  logic             ovf_reg, unf_reg;

  logic [5:0] off;
  logic       wr_en, opa_wr, opb_wr, cmd_wr, pop_wr, clr_wr;
  logic       unused_addr_lsbs;

  assign off              = addr[7:2];
  assign unused_addr_lsbs = ^addr[1:0];
  assign wr_en  = cs & we;
  assign opa_wr = wr_en && (off == OFF_OPA);
  assign opb_wr = wr_en && (off == OFF_OPB);
  assign cmd_wr = wr_en && (off == OFF_CMD);
  assign pop_wr = wr_en && (off == OFF_POP);
  assign clr_wr = wr_en && (off == OFF_CLEAR);

  logic cq_empty, cq_full, rq_empty, rq_full, has_credit;
  logic issue, cq_push, cmd_ovf, rq_pop, pop_unf;
  logic res_discard, res_done, rq_push, res_drop;
  logic [4:0] credit_used;

  assign cq_empty = (cq_count_reg == 4'd0);
  assign cq_full  = (cq_count_reg == 4'(CQ_DEPTH));
  assign rq_empty = (rq_count_reg == 4'd0);
  assign rq_full  = (rq_count_reg == 4'(RQ_DEPTH));

  // Every in-flight op already owns a result slot; issue only while a slot
  // remains unclaimed. Issue is also blocked until a CLEAR has drained.
  assign credit_used = {1'b0, rq_count_reg} + {1'b0, in_flight_reg};
  assign has_credit  = (credit_used < 5'(RQ_DEPTH));
  assign exu_valid   = !cq_empty && has_credit && (drain_reg == 4'd0);
  assign issue       = exu_valid && exu_ready;

  // A CMD into a full queue is still accepted if the head issues this cycle
  assign cq_push = cmd_wr && (!cq_full || issue);
  assign cmd_ovf = cmd_wr && cq_full && !issue;

  assign rq_pop  = pop_wr && !rq_empty;
  assign pop_unf = pop_wr && rq_empty;

  // Results returning while draining are discarded; otherwise they need an
  // outstanding op and a free slot (or a simultaneous pop).
  assign res_discard = res_valid && (drain_reg != 4'd0);
  assign res_done    = res_valid && (in_flight_reg != 4'd0);
  assign rq_push     = res_valid && (drain_reg == 4'd0) && (in_flight_reg != 4'd0)
                       && (!rq_full || rq_pop);
  assign res_drop    = res_valid && (drain_reg == 4'd0)
                       && ((in_flight_reg == 4'd0) || (rq_full && !rq_pop));

  always_comb begin
    in_flight_next = in_flight_reg;
    if (issue && !res_done && (in_flight_reg != 4'hF))
      in_flight_next = in_flight_reg + 4'd1;
    else if (!issue && res_done)
      in_flight_next = in_flight_reg - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cq_rd_ptr_reg <= '0;
      cq_wr_ptr_reg <= '0;
      rq_rd_ptr_reg <= '0;
      rq_wr_ptr_reg <= '0;
      cq_count_reg  <= '0;
      rq_count_reg  <= '0;
      in_flight_reg <= '0;
      drain_reg     <= '0;
      opa_reg       <= '0;
      opb_reg       <= '0;
      ovf_reg       <= 1'b0;
      unf_reg       <= 1'b0;
    end else begin
      in_flight_reg <= in_flight_next;
      if (opa_wr) opa_reg <= wdata;
      if (opb_wr) opb_reg <= wdata;

      if (clr_wr) begin
        // Ops already issued still come back; drain swallows them so they
        // never land in the freshly emptied result queue.
        cq_rd_ptr_reg <= '0;
        cq_wr_ptr_reg <= '0;
        rq_rd_ptr_reg <= '0;
        rq_wr_ptr_reg <= '0;
        cq_count_reg  <= '0;
        rq_count_reg  <= '0;
        ovf_reg       <= 1'b0;
        unf_reg       <= 1'b0;
        drain_reg     <= in_flight_next;
      end else begin
        if (res_discard) drain_reg <= drain_reg - 4'd1;

        if (cq_push) cq_wr_ptr_reg <= cq_wr_ptr_reg + CQ_AW'(1);
        if (issue)   cq_rd_ptr_reg <= cq_rd_ptr_reg + CQ_AW'(1);
        if (cq_push && !issue)      cq_count_reg <= cq_count_reg + 4'd1;
        else if (!cq_push && issue) cq_count_reg <= cq_count_reg - 4'd1;

        if (rq_push) rq_wr_ptr_reg <= rq_wr_ptr_reg + RQ_AW'(1);
        if (rq_pop)  rq_rd_ptr_reg <= rq_rd_ptr_reg + RQ_AW'(1);
        if (rq_push && !rq_pop)      rq_count_reg <= rq_count_reg + 4'd1;
        else if (!rq_push && rq_pop) rq_count_reg <= rq_count_reg - 4'd1;

        if (cmd_ovf || res_drop) ovf_reg <= 1'b1;
        if (pop_unf)             unf_reg <= 1'b1;
      end
    end
  end

  // Queue storage needs no reset: entries are only read between push and pop
  always_ff @(posedge clk) begin
    if (cq_push) cq_mem[cq_wr_ptr_reg] <= {wdata[1:0], opa_reg, opb_reg};
    if (rq_push) rq_mem[rq_wr_ptr_reg] <= {res_flags, res_data};
  end

  logic [65:0] cq_head;
  logic [35:0] rq_head;
  logic [31:0] head_result;
  logic [3:0]  head_flags;
  logic [31:0] status;

  assign cq_head     = cq_mem[cq_rd_ptr_reg];
  assign rq_head     = rq_mem[rq_rd_ptr_reg];
  assign exu_op      = cq_head[65:64];
  assign exu_a       = cq_head[63:32];
  assign exu_b       = cq_head[31:0];
  assign head_result = rq_empty ? 32'd0 : rq_head[31:0];
  assign head_flags  = rq_empty ? 4'd0 : rq_head[35:32];
  assign busy        = !cq_empty || (in_flight_reg != 4'd0);

  assign status = {4'd0, head_flags, 3'd0, busy, unf_reg, ovf_reg, rq_empty, cq_full,
                   4'd0, in_flight_reg, rq_count_reg, cq_count_reg};

  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_OPA:    rdata = opa_reg;
      OFF_OPB:    rdata = opb_reg;
      OFF_RESULT: rdata = head_result;
      OFF_STATUS: rdata = status;
      default:    rdata = 32'd0;
    endcase
  end

`ifndef SYNTHESIS
  // A result with nothing outstanding, or with no room, is a protocol error
  res_protocol_ok: assert property (@(posedge clk) disable iff (reset) !res_drop);
`endif

endmodule
